serlcd_uart_tx: RTL and testbench



---
 rtl/serlcd_uart_tx_if.sv | 18 +
 rtl/serlcd_uart_tx.sv | 146 ++++++++++++++
 tb/tb_serlcd_uart_tx.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serlcd_uart_tx_if.sv
// Byte handshake between the LCD command/text sequencer and the SerLCD UART transmitter.
interface serlcd_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/serlcd_uart_tx.sv
// 8N1 UART transmitter for the SerLCD RX pin, with a longer post-frame gap after the
// byte that follows the command prefix so the LCD firmware can finish the command.
module serlcd_uart_tx #(
  parameter int unsigned CLKS_PER_BIT   = 5208,
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned CMD_GAP_CYCLES = 250000,
  parameter logic [7:0]  CMD_PREFIX     = 8'hFE
) (
  input  logic              clk_50,
  input  logic              rst,
  serlcd_uart_tx_if.slave   bus,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned BitW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned GapMax = (GAP_CYCLES > CMD_GAP_CYCLES) ? GAP_CYCLES : CMD_GAP_CYCLES;
  localparam int unsigned GapW   = (GapMax > 0) ? $clog2(GapMax + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              cmd_pending_q, cmd_pending_d;
  logic              cmd_gap_q, cmd_gap_d;
  logic              tx_q, tx_d;

  logic              tx_ready;
  logic              accept;
  logic              bit_done;
  logic [GapW-1:0]   gap_len;

  assign tx_ready     = (state_q == StIdle) && !rst;
  assign bus.tx_ready = tx_ready;
  assign accept       = bus.tx_valid && tx_ready;
  assign bit_done     = (bit_cnt_q == BitW'(CLKS_PER_BIT - 1));
  assign gap_len      = cmd_gap_q ? GapW'(CMD_GAP_CYCLES) : GapW'(GAP_CYCLES);
  assign tx           = tx_q;
  assign busy         = (state_q != StIdle);

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    bit_idx_d     = bit_idx_q;
    gap_cnt_d     = gap_cnt_q;
    shift_d       = shift_q;
    cmd_pending_d = cmd_pending_q;
    cmd_gap_d     = cmd_gap_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d   = bus.tx_data;
          bit_cnt_d = '0;
          state_d   = StStart;
          // A pending prefix makes this byte the command, even if it is itself 0xFE.
          if (cmd_pending_q) begin
            cmd_gap_d     = 1'b1;
            cmd_pending_d = 1'b0;
          end else begin
            cmd_gap_d     = 1'b0;
            cmd_pending_d = (bus.tx_data == CMD_PREFIX);
          end
        end
      end
      StStart: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          bit_cnt_d = bit_cnt_q + BitW'(1);
        end
      end
      StData: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BitW'(1);
        end
      end
      StStop: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = (gap_len != '0) ? StGap : StIdle;
        end else begin
          bit_cnt_d = bit_cnt_q + BitW'(1);
        end
      end
      StGap: begin
        if (gap_cnt_q == gap_len - GapW'(1)) begin
          gap_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level follows the state being entered, so tx falls on the accept edge itself.
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      bit_idx_q     <= '0;
      gap_cnt_q     <= '0;
      shift_q       <= '0;
      cmd_pending_q <= 1'b0;
      cmd_gap_q     <= 1'b0;
      tx_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      bit_idx_q     <= bit_idx_d;
      gap_cnt_q     <= gap_cnt_d;
      shift_q       <= shift_d;
      cmd_pending_q <= cmd_pending_d;
      cmd_gap_q     <= cmd_gap_d;
      tx_q          <= tx_d;
    end
  end

endmodule

// File: tb/tb_serlcd_uart_tx.sv
// Self-checking bench for serlcd_uart_tx: frames are checked cycle by cycle against an
// 8N1 line model, and the post-frame gap against a prefix/command gap model.
module tb_serlcd_uart_tx;

  localparam int unsigned Cpb  = 4;
  localparam int unsigned Gap  = 2;
  localparam int unsigned CGap = 20;

  logic clk_50 = 1'b0;
  logic rst    = 1'b1;
  logic tx;
  logic busy;

  int tests = 0;
  int fails = 0;
  bit pend_m = 1'b0;

  serlcd_uart_tx_if bus ();

  serlcd_uart_tx #(
    .CLKS_PER_BIT   (Cpb),
    .GAP_CYCLES     (Gap),
    .CMD_GAP_CYCLES (CGap),
    .CMD_PREFIX     (8'hFE)
  ) dut (
    .clk_50 (clk_50),
    .rst    (rst),
    .bus    (bus),
    .tx     (tx),
    .busy   (busy)
  );

  always #5 clk_50 = ~clk_50;

  // Gap that follows a byte, updating the model's pending-prefix flag.
  function automatic int model_gap(input logic [7:0] b);
    if (pend_m) begin
      pend_m = 1'b0;
      return CGap;
    end
    if (b == 8'hFE) pend_m = 1'b1;
    return Gap;
  endfunction

  // Expected line level for each of the 10*Cpb cycles of a frame.
  function automatic logic [10*Cpb-1:0] model_line(input logic [7:0] b);
    logic [10*Cpb-1:0] l;
    for (int k = 0; k < 10 * Cpb; k++) begin
      int slot = k / Cpb;
      if (slot == 0)      l[k] = 1'b0;
      else if (slot == 9) l[k] = 1'b1;
      else                l[k] = b[slot-1];
    end
    return l;
  endfunction

  task automatic wait_ready(input logic [7:0] b, output bit ok);
    int t = 0;
    @(negedge clk_50);
    while (!bus.tx_ready && t < 200) begin
      @(negedge clk_50);
      t++;
    end
    ok = bus.tx_ready;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL accept_wait byte %h: tx_ready=%b after %0d cycles, required 1", b,
               bus.tx_ready, t);
    end
  endtask

  // Offer one byte, then check the whole frame, the gap and the ready/busy behaviour.
  task automatic send_check(input logic [7:0] b, input bit hold, input bit scramble);
    logic [10*Cpb-1:0] exp_line, got_line;
    int gap_exp, n;
    bit ok, ready_seen, busy_bad, gap_bad;
    ready_seen = 0;
    busy_bad   = 0;
    gap_bad    = 0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    wait_ready(b, ok);
    if (!ok) begin
      bus.tx_valid = 1'b0;
      return;
    end
    gap_exp  = model_gap(b);
    exp_line = model_line(b);
    @(posedge clk_50);
    #1;
    if (!hold) bus.tx_valid = 1'b0;
    for (int k = 0; k < 10 * Cpb; k++) begin
      got_line[k] = tx;
      if (bus.tx_ready) ready_seen = 1;
      if (busy !== 1'b1) busy_bad = 1;
      if (scramble) bus.tx_data = 8'($urandom);
      @(posedge clk_50);
      #1;
    end
    n = 0;
    while (!bus.tx_ready && n < 100) begin
      if (tx !== 1'b1) gap_bad = 1;
      if (busy !== 1'b1) busy_bad = 1;
      if (scramble) bus.tx_data = 8'($urandom);
      @(posedge clk_50);
      #1;
      n++;
    end
    if (busy !== 1'b0) busy_bad = 1;

    tests++;
    if (got_line !== exp_line) begin
      fails++;
      $display("FAIL frame byte %h: line %b, required %b", b, got_line, exp_line);
    end
    tests++;
    if (ready_seen) begin
      fails++;
      $display("FAIL ready_in_frame byte %h: tx_ready rose during frame, required low", b);
    end
    tests++;
    if (n != gap_exp) begin
      fails++;
      $display("FAIL gap byte %h: ready after %0d cycles from frame end, required %0d", b, n,
               gap_exp);
    end
    tests++;
    if (gap_bad || busy_bad) begin
      fails++;
      $display("FAIL gap_line byte %h: tx_low_in_gap=%b busy_wrong=%b, required 0/0", b,
               gap_bad, busy_bad);
    end
  endtask

  task automatic check_idle(input string name, input logic ready_req);
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || bus.tx_ready !== ready_req) begin
      fails++;
      $display("FAIL %s: tx=%b busy=%b tx_ready=%b, required 1/0/%b", name, tx, busy,
               bus.tx_ready, ready_req);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h41;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50);
      check_idle("reset_hold", 1'b0);
    end
    bus.tx_valid = 1'b0;
    rst = 1'b0;
    pend_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_50);
      check_idle("reset_release", 1'b1);
    end
  endtask

  task automatic test_single();
    send_check(8'h41, 1'b0, 1'b0);
  endtask

  task automatic test_cmd_pair();
    send_check(8'hFE, 1'b1, 1'b0);
    send_check(8'h01, 1'b1, 1'b0);
    send_check(8'h48, 1'b1, 1'b0);
    bus.tx_valid = 1'b0;
  endtask

  task automatic test_fe_fe();
    send_check(8'hFE, 1'b1, 1'b0);
    send_check(8'hFE, 1'b1, 1'b0);
    send_check(8'h41, 1'b1, 1'b0);
    bus.tx_valid = 1'b0;
    // No prefix may be left over: a plain 01 gets the ordinary gap.
    send_check(8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int dummy;
    bus.tx_data  = 8'h55;
    bus.tx_valid = 1'b1;
    wait_ready(8'h55, ok);
    if (ok) begin
      dummy = model_gap(8'h55);
      @(posedge clk_50);
      #1;
      bus.tx_valid = 1'b0;
      repeat (4 * Cpb + 1) @(posedge clk_50);
      #1;
      rst = 1'b1;
      @(posedge clk_50);
      #1;
      check_idle("reset_mid_data", 1'b0);
      rst = 1'b0;
      pend_m = 1'b0;
      @(negedge clk_50);
      check_idle("reset_mid_release", 1'b1);
    end
    send_check(8'h41, 1'b0, 1'b0);
    // FE then reset: the pending prefix must be dropped.
    send_check(8'hFE, 1'b0, 1'b0);
    @(posedge clk_50);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk_50);
    #1;
    rst = 1'b0;
    pend_m = 1'b0;
    send_check(8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    send_check(8'hA7, 1'b1, 1'b1);
    send_check(8'h3C, 1'b1, 1'b1);
    bus.tx_valid = 1'b0;
    @(negedge clk_50);
    check_idle("backpressure_idle", 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      send_check(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    bus.tx_valid = 1'b0;
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    test_reset();
    test_single();
    test_cmd_pair();
    test_fe_fe();
    test_reset_mid();
    test_backpressure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
